s27_bist_ctrl: RTL and testbench
================================

# s27_bist_ctrl

Built-in self-test controller for the s27 benchmark circuit. It drives the circuit's primary inputs G0..G3 with a flush pattern, then with LFSR pseudo-random patterns. It compacts the G17 response into a serial MISR signature and compares the result against a golden value. It instantiates beside `s27` in a test wrapper and sources the circuit's inputs and sinks its output.

## Interface
Parameters:
- NPAT, 255: number of pseudo-random patterns applied; legal range 1..255, enforced by an elaboration-time assertion.
- NFLUSH, 3: flush cycles before RUN, one per CUT flip-flop; legal range ≥1.
- FLUSH_PAT, 4'h0: value of {G3,G2,G1,G0} held during flush.
- SEED, 8'h01: LFSR load value; must be nonzero.
- GOLDEN, 16'h0000: expected final signature.

Ports:
- CK  input  1  clock, rising edge.
- RN  input  1  reset, asynchronous, active-low.
- START  input  1  test request; sampled only in IDLE and DONE.
- CUT_G17  input  1  response from s27 G17.
- PAT  output  4  {G3,G2,G1,G0} to the CUT.
- BUSY  output  1  high in FLUSH and RUN.
- DONE  output  1  high in DONE.
- PASS  output  1  valid while DONE=1; equals (SIG == GOLDEN).
- SIG  output  16  current MISR contents.

## Operation
- States: IDLE, FLUSH, RUN, DONE.
- IDLE
  - PAT=FLUSH_PAT.
  - START=1 loads LFSR←SEED, MISR←0, cnt←0, then enters FLUSH.
- FLUSH
  - PAT=FLUSH_PAT; MISR and LFSR hold.
  - After NFLUSH cycles, enter RUN with cnt←0.
- RUN
  - PAT=LFSR[3:0].
  - Each edge: MISR absorbs CUT_G17, LFSR steps, cnt increments.
  - After NPAT edges, enter DONE.
- DONE
  - PASS and SIG hold; PAT=FLUSH_PAT.
  - START=1 restarts exactly as from IDLE; DONE drops on that edge.
- LFSR: 8-bit Fibonacci, shift left; new LSB = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1), maximal length 255.
- MISR: 16-bit serial, polynomial x^16+x^12+x^5+1.
  - fb = SIG[15]^CUT_G17.
  - SIG_next = {SIG[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
- START while BUSY is ignored.
- The CUT has no reset. The FLUSH pattern is the only mechanism that brings it to a known state.

## Timing
- Reset (RN=0, async) values: state=IDLE, PAT=FLUSH_PAT, BUSY=0, DONE=0, PASS=0, SIG=16'h0000, LFSR=SEED, cnt=0.
- Reset mid-test aborts immediately; no partial result is reported.
- START sampled high at edge E:
  - BUSY=1 from E.
  - FLUSH occupies cycles E..E+NFLUSH-1.
  - RUN occupies cycles E+NFLUSH..E+NFLUSH+NPAT-1.
  - DONE=1 and BUSY=0 from edge E+NFLUSH+NPAT.
- Total busy time: NFLUSH+NPAT cycles.
- Each pattern is stable for one full cycle. CUT_G17 is sampled at the edge that ends that pattern's cycle, giving zero extra pipeline latency. The CUT combinational path therefore must close within one CK period.
- PASS is registered; it updates on the same edge DONE rises, from the final MISR value.
- All outputs are registered except PAT, which decodes state plus LFSR and is glitch-free per state.

## Structure
- Package `s27_bist_pkg` holds:
  - state enum;
  - LFSR_W=8, SIG_W=16;
  - MISR_POLY=16'h1021;
  - LFSR tap mask 8'hB8.
- Counter width is $clog2(max(NPAT,NFLUSH)+1).
- One sub-module: `s27_misr`, the serial MISR with clear and enable inputs.
- The LFSR and FSM stay inline.

## Test plan
- Reset check: assert RN=0 mid-RUN → BUSY=0, DONE=0, SIG=0000, PAT=FLUSH_PAT that same cycle; deassert RN → IDLE.
- Pattern sequence: NPAT=4, SEED=01, NFLUSH=3 → PAT=0 for 3 cycles, then 1,2,4,8; DONE rises exactly 7 cycles after the START edge.
- Zero response: CUT_G17 tied 0, NPAT=255 → SIG=0000; PASS=1 with GOLDEN=0000; PASS=0 with GOLDEN=0001.
- Single one: NPAT=1, CUT_G17=1 during RUN → SIG=1021 at DONE.
- Control edge cases:
  - START pulsed while BUSY → no restart; timing unchanged.
  - START in DONE → DONE falls on that edge, SIG cleared, full sequence reruns.
- Live CUT: drive s27 with a golden model over NPAT=255 → SIG matches the model's signature, PASS=1. Inject a stuck-at-0 on G17 → PASS=0.

Source files
------------

// File: rtl/s27_bist_pkg.sv
// -----------------------------------------------------------------------------
// s27_bist_pkg
// Shared types and constants for the s27 BIST controller and its MISR.
//   state_t    : controller FSM states (IDLE, FLUSH, RUN, DONE)
//   LFSR_W     : pattern generator width
//   SIG_W      : signature register width
//   MISR_POLY  : x^16 + x^12 + x^5 + 1 feedback mask
//   LFSR_TAPS  : x^8 + x^6 + x^5 + x^4 + 1 tap mask (bits 7,5,4,3)
//   lfsr_step  : one Fibonacci shift-left step of the pattern LFSR
// -----------------------------------------------------------------------------
package s27_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LFSR_W = 8;
    localparam int SIG_W  = 16;

    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Shift left; the new LSB is the XOR of the tapped bits. With a nonzero
    // seed this walks all 255 nonzero states before repeating.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/s27_misr.sv
// -----------------------------------------------------------------------------
// s27_misr
// Serial-input signature register compacting the CUT response stream.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the signature
//   clr      : synchronous clear (start of a new test)
//   en       : absorb din on this edge
//   din      : serial response bit
//   sig      : current signature
//   sig_next : value the signature takes if en is high on the next edge;
//              lets the controller grade the final signature on the same
//              edge it is formed
// -----------------------------------------------------------------------------
module s27_misr
    import s27_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    logic fb;

    always_comb begin
        fb       = sig[SIG_W-1] ^ din;
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
    end

    // Clear wins over enable so a restart never mixes in a stale bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s27_bist_ctrl.sv
// -----------------------------------------------------------------------------
// s27_bist_ctrl
// BIST controller for the s27 benchmark circuit. Applies a flush pattern to
// bring the CUT flip-flops to a known state, then NPAT LFSR patterns, while a
// 16-bit MISR compacts G17. The final signature is compared with GOLDEN.
// Parameters:
//   NPAT      : pseudo-random patterns applied (1..255)
//   NFLUSH    : flush cycles before RUN (>= 1)
//   FLUSH_PAT : {G3,G2,G1,G0} held outside RUN
//   SEED      : LFSR load value (nonzero)
//   GOLDEN    : expected final signature
// Ports:
//   CK        : clock, rising edge
//   RN        : asynchronous active-low reset
//   START     : test request
//   CUT_G17   : CUT response
//   PAT       : {G3,G2,G1,G0} to the CUT (decoded from state and LFSR)
//   BUSY      : high in FLUSH and RUN
//   DONE      : high in DONE
//   PASS      : valid while DONE; SIG == GOLDEN
//   SIG       : current MISR contents
//   dbg_state : current FSM state, for checkers and debug
//
// START is a level-sampled request, not a valid/ready handshake: it is looked
// at only on edges where the controller sits in IDLE or DONE, and it is acted
// on in that same edge. While BUSY it is ignored; there is no back-pressure,
// queueing or acknowledge beyond BUSY rising.
// -----------------------------------------------------------------------------
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int                NPAT      = 255,
    parameter int                NFLUSH    = 3,
    parameter logic [3:0]        FLUSH_PAT = 4'h0,
    parameter logic [LFSR_W-1:0] SEED      = 8'h01,
    parameter logic [SIG_W-1:0]  GOLDEN    = 16'h0000
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             CUT_G17,
    output logic [3:0]       PAT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG,
    output logic [1:0]       dbg_state
);

    // One counter serves both the flush and run phases.
    localparam int CNT_MAX = (NPAT > NFLUSH) ? NPAT : NFLUSH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(NFLUSH - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NPAT - 1);

    if ((NPAT < 1) || (NPAT > 255)) begin : g_bad_npat
        $error("s27_bist_ctrl: NPAT must be in 1..255");
    end
    if (NFLUSH < 1) begin : g_bad_nflush
        $error("s27_bist_ctrl: NFLUSH must be at least 1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("s27_bist_ctrl: SEED must be nonzero");
    end

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              start_ok;
    logic              misr_clr;
    logic              misr_en;
    logic [SIG_W-1:0]  sig_now;
    logic [SIG_W-1:0]  sig_next;

    // A request is only honoured when the controller is at rest.
    always_comb begin
        start_ok = START && ((state == ST_IDLE) || (state == ST_DONE));
        misr_clr = start_ok;
        misr_en  = (state == ST_RUN);
    end

    s27_misr u_misr (
        .clk      (CK),
        .rst_n    (RN),
        .clr      (misr_clr),
        .en       (misr_en),
        .din      (CUT_G17),
        .sig      (sig_now),
        .sig_next (sig_next)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= ST_IDLE;
            lfsr   <= SEED;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state  <= ST_FLUSH;
                        lfsr   <= SEED;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                    end
                end

                // LFSR and MISR hold while the CUT flip-flops settle.
                ST_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The response to the pattern shown this cycle is absorbed
                // on the edge that ends the cycle, as the LFSR moves on.
                ST_RUN: begin
                    lfsr <= lfsr_step(lfsr);
                    if (cnt == RUN_LAST) begin
                        state  <= ST_DONE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // Graded on sig_next: the MISR takes this value on
                        // the same edge, so PASS and SIG agree from DONE on.
                        pass_q <= (sig_next == GOLDEN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    pass_q <= 1'b0;
                end
            endcase
        end
    end

    // PAT is a pure decode of registered state: constant within a state
    // except in RUN, where it follows the registered LFSR.
    always_comb begin
        PAT = (state == ST_RUN) ? lfsr[3:0] : FLUSH_PAT;
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign SIG       = sig_now;
    assign dbg_state = state;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s27_bist_ctrl
// Directed bench for s27_bist_ctrl. Several controller instances with
// different parameters share one clock and reset:
//   u_seq  : NPAT=4, GOLDEN=8108, bench-driven response
//   u_one  : NPAT=1, GOLDEN=1021, bench-driven response
//   u_z0   : NPAT=255, GOLDEN=0000, response tied 0
//   u_z1   : NPAT=255, GOLDEN=0001, response tied 0
//   u_live : NPAT=255, drives a behavioural s27, GOLDEN from a model
//   u_sa0  : same GOLDEN as u_live, response stuck at 0
// -----------------------------------------------------------------------------
module tb_s27_bist_ctrl;

    // ---------------- clock / reset ----------------
    logic ck = 1'b0;
    logic rn = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // ---------------- s27 golden model ----------------
    // st = {G7,G6,G5}; returns {G17, next {G7,G6,G5}}.
    function automatic logic [3:0] s27_eval(input logic [3:0] p, input logic [2:0] st);
        logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g14 = ~p[0];
        g8  = g14 & st[1];
        g12 = ~(p[1] | st[2]);
        g15 = g12 | g8;
        g16 = p[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[0] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(p[2] | g12);
        return {~g11, g13, g11, g10};
    endfunction

    // Flush pattern C = {G3=1,G2=1,G1=0,G0=0} forces G5=G7=0 after one cycle
    // and G6=1 after two, from any starting state.
    function automatic logic [15:0] calc_live_golden();
        logic [2:0]  st;
        logic [7:0]  lf;
        logic [15:0] s;
        logic [3:0]  r;
        logic        fb;
        st = 3'b000;
        lf = 8'h01;
        s  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            r  = s27_eval(4'hC, st);
            st = r[2:0];
        end
        for (int i = 0; i < 255; i++) begin
            r  = s27_eval(lf[3:0], st);
            fb = s[15] ^ r[3];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            st = r[2:0];
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
        return s;
    endfunction

    localparam logic [15:0] LIVE_GOLDEN = calc_live_golden();

    // ---------------- DUT signals ----------------
    logic        start_seq = 1'b0, g17_seq = 1'b0;
    logic [3:0]  pat_seq;
    logic        busy_seq, done_seq, pass_seq;
    logic [15:0] sig_seq;
    logic [1:0]  st_seq;

    logic        start_one = 1'b0, g17_one = 1'b0;
    logic [3:0]  pat_one;
    logic        busy_one, done_one, pass_one;
    logic [15:0] sig_one;
    logic [1:0]  st_one;

    logic        start_long = 1'b0;
    logic [3:0]  pat_z0, pat_z1, pat_live, pat_sa0;
    logic        busy_z0, busy_z1, busy_live, busy_sa0;
    logic        done_z0, done_z1, done_live, done_sa0;
    logic        pass_z0, pass_z1, pass_live, pass_sa0;
    logic [15:0] sig_z0, sig_z1, sig_live, sig_sa0;
    logic [1:0]  st_z0, st_z1, st_live, st_sa0;

    // Behavioural s27 hooked to u_live; no reset, like the real CUT.
    logic [2:0] cut_st;
    logic [3:0] cut_out;
    logic       g17_live;
    always_comb cut_out = s27_eval(pat_live, cut_st);
    assign g17_live = cut_out[3];
    always @(posedge ck) cut_st <= cut_out[2:0];

    s27_bist_ctrl #(.NPAT(4), .NFLUSH(3), .FLUSH_PAT(4'h0), .SEED(8'h01), .GOLDEN(16'h8108)) u_seq (
        .CK(ck), .RN(rn), .START(start_seq), .CUT_G17(g17_seq), .PAT(pat_seq), .BUSY(busy_seq),
        .DONE(done_seq), .PASS(pass_seq), .SIG(sig_seq), .dbg_state(st_seq));

    s27_bist_ctrl #(.NPAT(1), .NFLUSH(3), .FLUSH_PAT(4'h0), .SEED(8'h01), .GOLDEN(16'h1021)) u_one (
        .CK(ck), .RN(rn), .START(start_one), .CUT_G17(g17_one), .PAT(pat_one), .BUSY(busy_one),
        .DONE(done_one), .PASS(pass_one), .SIG(sig_one), .dbg_state(st_one));

    s27_bist_ctrl #(.NPAT(255), .NFLUSH(3), .FLUSH_PAT(4'h0), .SEED(8'h01), .GOLDEN(16'h0000)) u_z0 (
        .CK(ck), .RN(rn), .START(start_long), .CUT_G17(1'b0), .PAT(pat_z0), .BUSY(busy_z0),
        .DONE(done_z0), .PASS(pass_z0), .SIG(sig_z0), .dbg_state(st_z0));

    s27_bist_ctrl #(.NPAT(255), .NFLUSH(3), .FLUSH_PAT(4'h0), .SEED(8'h01), .GOLDEN(16'h0001)) u_z1 (
        .CK(ck), .RN(rn), .START(start_long), .CUT_G17(1'b0), .PAT(pat_z1), .BUSY(busy_z1),
        .DONE(done_z1), .PASS(pass_z1), .SIG(sig_z1), .dbg_state(st_z1));

    s27_bist_ctrl #(.NPAT(255), .NFLUSH(3), .FLUSH_PAT(4'hC), .SEED(8'h01), .GOLDEN(LIVE_GOLDEN)) u_live (
        .CK(ck), .RN(rn), .START(start_long), .CUT_G17(g17_live), .PAT(pat_live), .BUSY(busy_live),
        .DONE(done_live), .PASS(pass_live), .SIG(sig_live), .dbg_state(st_live));

    s27_bist_ctrl #(.NPAT(255), .NFLUSH(3), .FLUSH_PAT(4'hC), .SEED(8'h01), .GOLDEN(LIVE_GOLDEN)) u_sa0 (
        .CK(ck), .RN(rn), .START(start_long), .CUT_G17(1'b0), .PAT(pat_sa0), .BUSY(busy_sa0),
        .DONE(done_sa0), .PASS(pass_sa0), .SIG(sig_sa0), .dbg_state(st_sa0));

    // Expected PAT per cycle for NFLUSH=3, NPAT=4, SEED=01, FLUSH_PAT=0.
    logic [3:0] exp_pat [7];
    initial exp_pat = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

    // ---------------- tests ----------------
    task automatic test_reset();
        rn = 1'b0;
        repeat (2) @(negedge ck);
        checks++;
        if ({busy_seq, done_seq, pass_seq} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b, expected 000", {busy_seq, done_seq, pass_seq});
        end
        checks++;
        if (sig_seq !== 16'h0000) begin
            errors++; $display("FAIL reset_sig: got %h, expected 0000", sig_seq);
        end
        checks++;
        if ({st_seq, st_one, st_z0, st_z1, st_live, st_sa0} !== 12'h000) begin
            errors++; $display("FAIL reset_state: got %h, expected 000", {st_seq, st_one, st_z0, st_z1, st_live, st_sa0});
        end
        checks++;
        if ({pat_seq, pat_one, pat_z0, pat_z1, pat_live, pat_sa0} !== 24'h0000CC) begin
            errors++; $display("FAIL reset_pat: got %h, expected 0000cc", {pat_seq, pat_one, pat_z0, pat_z1, pat_live, pat_sa0});
        end
        rn = 1'b1;
        @(negedge ck);

        // Abort in the middle of RUN with a nonzero signature.
        g17_seq   = 1'b1;
        start_seq = 1'b1;
        @(negedge ck);
        start_seq = 1'b0;
        repeat (4) @(negedge ck);
        checks++;
        if ({pat_seq, busy_seq, sig_seq} !== {4'h2, 1'b1, 16'h1021}) begin
            errors++; $display("FAIL midrun_pre: got pat=%h busy=%b sig=%h, expected pat=2 busy=1 sig=1021", pat_seq, busy_seq, sig_seq);
        end
        rn = 1'b0;
        #1;
        checks++;
        if ({busy_seq, done_seq, pass_seq, st_seq} !== 5'b00000) begin
            errors++; $display("FAIL midrun_rst_flags: got busy=%b done=%b pass=%b st=%0d, expected 0 0 0 0", busy_seq, done_seq, pass_seq, st_seq);
        end
        checks++;
        if ({sig_seq, pat_seq} !== {16'h0000, 4'h0}) begin
            errors++; $display("FAIL midrun_rst_out: got sig=%h pat=%h, expected sig=0000 pat=0", sig_seq, pat_seq);
        end
        g17_seq = 1'b0;
        @(negedge ck);
        rn = 1'b1;
        repeat (2) @(negedge ck);
        checks++;
        if ({st_seq, busy_seq, done_seq} !== 4'b0000) begin
            errors++; $display("FAIL post_rst_idle: got st=%0d busy=%b done=%b, expected 0 0 0", st_seq, busy_seq, done_seq);
        end
    endtask

    task automatic test_pattern_seq();
        start_seq = 1'b1;
        @(negedge ck);
        start_seq = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge ck);
            checks++;
            if ({pat_seq, busy_seq, done_seq} !== {exp_pat[i], 1'b1, 1'b0}) begin
                errors++; $display("FAIL seq_cycle%0d: got pat=%h busy=%b done=%b, expected pat=%h busy=1 done=0", i, pat_seq, busy_seq, done_seq, exp_pat[i]);
            end
            g17_seq = (i == 3);
        end
        @(negedge ck);
        g17_seq = 1'b0;
        checks++;
        if ({done_seq, busy_seq, pat_seq} !== {1'b1, 1'b0, 4'h0}) begin
            errors++; $display("FAIL seq_done: got done=%b busy=%b pat=%h, expected 1 0 0", done_seq, busy_seq, pat_seq);
        end
        checks++;
        if ({sig_seq, pass_seq} !== {16'h8108, 1'b1}) begin
            errors++; $display("FAIL seq_sig: got sig=%h pass=%b, expected 8108 1", sig_seq, pass_seq);
        end
        repeat (2) @(negedge ck);
        checks++;
        if ({done_seq, sig_seq, pass_seq} !== {1'b1, 16'h8108, 1'b1}) begin
            errors++; $display("FAIL seq_hold: got done=%b sig=%h pass=%b, expected 1 8108 1", done_seq, sig_seq, pass_seq);
        end
    endtask

    task automatic test_start_in_done_and_busy();
        start_seq = 1'b1;
        @(negedge ck);
        start_seq = 1'b0;
        checks++;
        if ({done_seq, busy_seq, sig_seq, pass_seq} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL restart_edge: got done=%b busy=%b sig=%h pass=%b, expected 0 1 0000 0", done_seq, busy_seq, sig_seq, pass_seq);
        end
        // START pulses at cycles 2 and 4 land while BUSY and must be ignored.
        for (int i = 1; i < 7; i++) begin
            @(negedge ck);
            checks++;
            if ({pat_seq, busy_seq, done_seq} !== {exp_pat[i], 1'b1, 1'b0}) begin
                errors++; $display("FAIL busy_start_cycle%0d: got pat=%h busy=%b done=%b, expected pat=%h busy=1 done=0", i, pat_seq, busy_seq, done_seq, exp_pat[i]);
            end
            start_seq = (i == 2) || (i == 4);
        end
        @(negedge ck);
        start_seq = 1'b0;
        checks++;
        if ({done_seq, busy_seq, sig_seq, pass_seq} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL busy_start_done: got done=%b busy=%b sig=%h pass=%b, expected 1 0 0000 0", done_seq, busy_seq, sig_seq, pass_seq);
        end
    endtask

    task automatic test_single_one();
        // Response held 1 through flush too: the MISR must ignore it there.
        g17_one   = 1'b1;
        start_one = 1'b1;
        @(negedge ck);
        start_one = 1'b0;
        repeat (3) @(negedge ck);
        checks++;
        if ({pat_one, busy_one, sig_one} !== {4'h1, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL one_run: got pat=%h busy=%b sig=%h, expected 1 1 0000", pat_one, busy_one, sig_one);
        end
        @(negedge ck);
        g17_one = 1'b0;
        checks++;
        if ({done_one, busy_one, sig_one, pass_one} !== {1'b1, 1'b0, 16'h1021, 1'b1}) begin
            errors++; $display("FAIL one_done: got done=%b busy=%b sig=%h pass=%b, expected 1 0 1021 1", done_one, busy_one, sig_one, pass_one);
        end
    endtask

    task automatic test_long_runs();
        int cyc;
        start_long = 1'b1;
        @(negedge ck);
        start_long = 1'b0;
        cyc = 0;
        while (!done_z0 && cyc < 400) begin
            @(negedge ck);
            cyc++;
        end
        checks++;
        if ((done_z0 !== 1'b1) || (cyc != 258)) begin
            errors++; $display("FAIL long_latency: got done=%b after %0d cycles, expected done=1 after 258", done_z0, cyc);
        end
        checks++;
        if ({done_z1, done_live, done_sa0, busy_z0, busy_live} !== 5'b11100) begin
            errors++; $display("FAIL long_flags: got %b, expected 11100", {done_z1, done_live, done_sa0, busy_z0, busy_live});
        end
        checks++;
        if ({sig_z0, pass_z0} !== {16'h0000, 1'b1}) begin
            errors++; $display("FAIL zero_golden0: got sig=%h pass=%b, expected 0000 1", sig_z0, pass_z0);
        end
        checks++;
        if ({sig_z1, pass_z1} !== {16'h0000, 1'b0}) begin
            errors++; $display("FAIL zero_golden1: got sig=%h pass=%b, expected 0000 0", sig_z1, pass_z1);
        end
        checks++;
        if ({sig_live, pass_live} !== {LIVE_GOLDEN, 1'b1}) begin
            errors++; $display("FAIL live_cut: got sig=%h pass=%b, expected %h 1", sig_live, pass_live, LIVE_GOLDEN);
        end
        checks++;
        if ({sig_sa0, pass_sa0, busy_z1, busy_sa0} !== {16'h0000, 1'b0, 2'b00}) begin
            errors++; $display("FAIL stuck_at0: got sig=%h pass=%b busy=%b%b, expected 0000 0 00", sig_sa0, pass_sa0, busy_z1, busy_sa0);
        end
        checks++;
        if ({pat_z0, pat_z1, pat_live, pat_sa0} !== 16'h00CC) begin
            errors++; $display("FAIL long_done_pat: got %h, expected 00cc", {pat_z0, pat_z1, pat_live, pat_sa0});
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_pattern_seq();
        test_start_in_done_and_busy();
        test_single_one();
        test_long_runs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors so far", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
